// File: rtl/ntt_seq_ctrl.sv
// rtl/ntt_seq_ctrl.sv - NTT core sequencer: coefficient load, run handshake, paired readback
// Optional watchdog on WAIT_INIT/RUN enabled by defining NTT_SEQ_TIMEOUT_EN.
module ntt_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data_a,
  input  logic [15:0] in_data_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data_a,
  output logic [15:0] out_data_b,
  output logic        busy,
  output logic        err,
  output logic        ntt_start,
  output logic        ntt_mode,
  output logic        ntt_we,
  output logic [7:0]  ntt_addr_a,
  output logic [7:0]  ntt_addr_b,
  output logic [15:0] ntt_din_a,
  output logic [15:0] ntt_din_b,
  input  logic [15:0] ntt_dout1,
  input  logic [15:0] ntt_dout2,
  input  logic        ntt_init_done,
  input  logic        ntt_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_INIT, S_RUN, S_READ, S_CAPT, S_HOLD, S_ERR
  } state_t;

  state_t     state;
  logic [6:0] pc;
  logic       load_fire;
  logic       timeout;

  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign ntt_start = (state != S_RUN);
  assign load_fire = in_ready && in_valid;
  assign ntt_we    = load_fire;

  // Address/data buses stay at zero unless a write or a read is actually issued.
  always_comb begin
    ntt_addr_a = '0;
    ntt_addr_b = '0;
    ntt_din_a  = '0;
    ntt_din_b  = '0;
    if (load_fire) begin
      ntt_addr_a = {pc, 1'b0};
      ntt_addr_b = {pc, 1'b1};
      ntt_din_a  = in_data_a;
      ntt_din_b  = in_data_b;
    end else if (state == S_READ) begin
      ntt_addr_a = {pc, 1'b0};
      ntt_addr_b = {pc, 1'b1};
    end
  end

`ifdef NTT_SEQ_TIMEOUT_EN
  logic [15:0] wd;

  assign timeout = (int'(wd) + 1 >= TIMEOUT_CYCLES);
  assign err     = (state == S_ERR);

  // Counter is zero on the first cycle of WAIT_INIT and again on the first cycle of RUN.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      wd <= '0;
    end else if ((state != S_WAIT_INIT && state != S_RUN) ||
                 (state == S_WAIT_INIT && ntt_init_done)) begin
      wd <= '0;
    end else begin
      wd <= wd + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign err                = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      out_valid  <= 1'b0;
      out_data_a <= '0;
      out_data_b <= '0;
      ntt_mode   <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          ntt_mode <= cmd_mode;
          pc       <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          if (pc == 7'd127) begin
            pc    <= '0;
            state <= S_WAIT_INIT;
          end else begin
            pc <= pc + 7'd1;
          end
        end
        S_WAIT_INIT: begin
          if (ntt_init_done)  state <= S_RUN;
          else if (timeout)   state <= S_ERR;
        end
        S_RUN: begin
          if (ntt_done) begin
            pc    <= '0;
            state <= S_READ;
          end else if (timeout) begin
            state <= S_ERR;
          end
        end
        S_READ: state <= S_CAPT;
        // Core read data arrives one cycle after the address was presented in READ.
        S_CAPT: begin
          out_data_a <= ntt_dout1;
          out_data_b <= ntt_dout2;
          out_valid  <= 1'b1;
          state      <= S_HOLD;
        end
        S_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          if (pc == 7'd127) begin
            pc    <= '0;
            state <= S_IDLE;
          end else begin
            pc    <= pc + 7'd1;
            state <= S_READ;
          end
        end
        S_ERR: state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
